apb_initiator: RTL

- APB initiator that turns core load/store requests (valid/ready) into APB4 setup/access transfers toward the address decoder/interconnect.
- Sits between the core's memory port and the decoder: drives paddr/pdata/psel/penable/pwrite/pstb; consumes prdata/pready/perr.
- Adds a wait-state timeout so a hung completer cannot stall the core.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_timeout_counter.sv | 30 +++
 rtl/apb_initiator.sv | 107 ++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator: FSM state encoding and default bus widths.
package apb_pkg;

  localparam int APB_STRB_W     = 4;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// Wait-state counter: cleared before each ACCESS phase, counts stalled cycles and
// saturates. expired flags the stalled cycle that completes LIMIT stalls (never when LIMIT=0).
module apb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'((LIMIT == 0) ? 0 : LIMIT - 1);
  localparam bit ENABLED = (LIMIT != 0);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the stall that would bring the count to LIMIT, so exactly LIMIT ACCESS cycles elapse.
  assign expired = ENABLED && en && (count == LAST);

endmodule

// File: rtl/apb_initiator.sv
// APB4 initiator: converts core valid/ready load/store requests into SETUP/ACCESS
// transfers and returns a one-cycle completion pulse, with a wait-state timeout.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [APB_STRB_W-1:0] req_strb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [APB_STRB_W-1:0] pstb,
  input  logic                  pready,
  input  logic                  perr
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // rsp_valid is a single-cycle pulse, rsp_rdata/rsp_err hold until the next completion.

  apb_state_e state, state_nxt;
  logic       accept;
  logic       in_access;
  logic       wait_expired;

  assign accept    = (state == IDLE) && req_valid;
  assign in_access = (state == ACCESS);

  apb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (pclk),
    .rst    (rst),
    .clear  (state == SETUP),
    .en     (in_access && !pready),
    .expired(wait_expired)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || wait_expired) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    psel      = (state != IDLE);
    penable   = (state == ACCESS);
  end

  // Request fields are latched only on acceptance, so they stay stable for the whole transfer.
  always_ff @(posedge pclk) begin
    if (rst) begin
      paddr     <= '0;
      pdata     <= '0;
      pwrite    <= 1'b0;
      pstb      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        paddr  <= req_addr;
        pdata  <= req_wdata;
        pwrite <= req_write;
        pstb   <= req_write ? req_strb : '0;
      end
      if (in_access && pready) begin
        rsp_valid <= 1'b1;
        rsp_err   <= perr;
        rsp_rdata <= pwrite ? '0 : prdata;
      end else if (wait_expired) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule
